// File: rtl/serializer.sv
// Parallel-to-serial converter: captures a WIDTH-bit word and shifts it out MSB first,
// one bit per clock, streaming back-to-back words with no gap while load stays high.
module serializer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic             Ren,
  output logic             out
);

  localparam int unsigned      CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic             w_last;
  logic             w_capture;

  // A new word may enter when idle or on the edge that retires the last bit.
  assign w_last    = (r_cnt == LAST);
  assign w_capture = ~rst & load & ((r_state == IDLE) | ((r_state == SHIFT) & w_last));

  assign Ren = w_capture;
  // The shift register is cleared whenever idle, so its MSB is already 0 there.
  assign out = r_shift[WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (w_capture) begin
      r_state <= SHIFT;
      r_shift <= data;
      r_cnt   <= '0;
    end else if (r_state == SHIFT) begin
      if (w_last) begin
        r_state <= IDLE;
        r_shift <= '0;
        r_cnt   <= '0;
      end else begin
        r_shift <= {r_shift[WIDTH-2:0], 1'b0};
        r_cnt   <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_serializer.sv
// Directed self-checking bench for serializer (WIDTH=32): reset, single word,
// mid-word data change, streaming, ignored load pulses and mid-word reset.
module tb_serializer;

  logic        clk;
  logic        rst;
  logic        load;
  logic [31:0] data;
  logic        Ren;
  logic        out;

  int unsigned n_cmp;
  int unsigned n_err;

  localparam logic [31:0] W1 = 32'h65D9_6B66;
  localparam logic [31:0] W2 = 32'h001F_FFFC;
  localparam logic [31:0] W3 = 32'hB5E7_3C1D;
  localparam logic [31:0] S0 = 32'hA5C3_0F96;
  localparam logic [31:0] S1 = 32'h1234_5678;
  localparam logic [31:0] S2 = 32'hFEDC_BA98;

  serializer #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .data (data),
    .Ren  (Ren),
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs on the falling edge, then check out and Ren.
  task automatic cyc(input logic ld, input logic [31:0] d, input logic e_ren,
                     input logic e_out, input string tag);
    @(negedge clk);
    load = ld;
    data = d;
    #1;
    check($sformatf("%s.out", tag), 32'(out), 32'(e_out));
    check($sformatf("%s.ren", tag), 32'(Ren), 32'(e_ren));
  endtask

  logic [31:0] seq_word;
  logic [31:0] seq_exp;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    load  = 1'bx;
    data  = 'x;

    // Reset with undriven inputs: nothing may reach out or Ren.
    for (int i = 0; i < 2; i++) cyc(1'bx, 'x, 1'b0, 1'b0, $sformatf("rst_x%0d", i));

    @(negedge clk);
    rst  = 1'b0;
    load = 1'b0;
    data = '0;
    cyc(1'b0, 32'h0, 1'b0, 1'b0, "idle_noload");

    // Single word, load for one cycle; explicit expected bit sequence.
    seq_exp = 32'b0110_0101_1101_1001_0110_1011_0110_0110;
    cyc(1'b1, W1, 1'b1, 1'b0, "single_cap");
    for (int i = 0; i < 32; i++)
      cyc(1'b0, 32'hFFFF_FFFF, 1'b0, seq_exp[31-i], $sformatf("single_b%0d", i));
    cyc(1'b0, 32'h0, 1'b0, 1'b0, "single_idle0");
    cyc(1'b0, 32'h0, 1'b0, 1'b0, "single_idle1");

    // Load held high, data switches after 20 clocks; second word is 11x0,19x1,2x0.
    seq_exp = {11'h000, 19'h7FFFF, 2'b00};
    cyc(1'b1, W1, 1'b1, 1'b0, "mw_cap");
    for (int i = 0; i < 32; i++)
      cyc(1'b1, (i >= 20) ? W2 : W1, (i == 31), W1[31-i], $sformatf("mw_a_b%0d", i));
    for (int i = 0; i < 32; i++)
      cyc(1'b0, 32'h0, 1'b0, seq_exp[31-i], $sformatf("mw_b_b%0d", i));
    cyc(1'b0, 32'h0, 1'b0, 1'b0, "mw_idle");

    // Three words streamed with no gap; load drops during the last word.
    cyc(1'b1, S0, 1'b1, 1'b0, "str_cap");
    for (int w = 0; w < 3; w++) begin
      seq_word = (w == 0) ? S0 : (w == 1) ? S1 : S2;
      for (int i = 0; i < 32; i++)
        cyc((w < 2), (i == 31) ? ((w == 0) ? S1 : S2) : 32'h0,
            (i == 31) && (w < 2), seq_word[31-i], $sformatf("str_w%0d_b%0d", w, i));
    end
    cyc(1'b0, 32'h0, 1'b0, 1'b0, "str_idle");

    // load pulses at bits 5 and 20 are ignored and do not disturb the word.
    cyc(1'b1, W3, 1'b1, 1'b0, "ign_cap");
    for (int i = 0; i < 32; i++)
      cyc((i == 5) || (i == 20), ~W3, 1'b0, W3[31-i], $sformatf("ign_b%0d", i));
    cyc(1'b0, 32'h0, 1'b0, 1'b0, "ign_idle");

    // Reset while bit 10 (a 1) is on the line clears out without a clock edge.
    cyc(1'b1, W3, 1'b1, 1'b0, "rmw_cap");
    for (int i = 0; i <= 10; i++)
      cyc(1'b0, 32'h0, 1'b0, W3[31-i], $sformatf("rmw_b%0d", i));
    #2;
    rst  = 1'b1;
    load = 1'b1;
    #1;
    check("rmw_async_out", 32'(out), 32'h0);
    check("rmw_async_ren", 32'(Ren), 32'h0);
    @(posedge clk);
    #1;
    check("rmw_hold_out", 32'(out), 32'h0);
    check("rmw_hold_ren", 32'(Ren), 32'h0);
    @(negedge clk);
    rst  = 1'b0;
    load = 1'b0;
    for (int i = 0; i < 34; i++)
      cyc(1'b0, W3, 1'b0, 1'b0, $sformatf("rmw_post%0d", i));

    // First load after reset release captures immediately.
    cyc(1'b1, W2, 1'b1, 1'b0, "post_rst_cap");
    cyc(1'b0, 32'h0, 1'b0, W2[31], "post_rst_b0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serializer.md
SERIALIZER -- requirements
Module: serializer

Interface
REQ-001 Parameter WIDTH, default 32, meaning: parallel word width in bits; legal range 2..64.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-high.
REQ-004 load  input  1  upstream word-available strobe; sampled on rising edge of clk.
REQ-005 data  input  WIDTH  parallel word; sampled only on a capture edge (REQ-009).
REQ-006 Ren  output  1  read-enable/acknowledge; high in the cycle whose rising edge captures data; upstream pops its word on that edge.
REQ-007 out  output  1  serial bit stream, MSB first, one bit per clock.

Function
REQ-008 Two states SHALL exist:
- IDLE: no word in flight.
- SHIFT: word being transmitted.
Internal registers SHALL be a WIDTH-bit shift register and a bit counter of ceil(log2(WIDTH)) bits.
REQ-009 A capture SHALL occur on a rising edge when load=1 and either:
- state is IDLE, or
- state is SHIFT and bit counter = WIDTH-1.
REQ-010 Ren SHALL be combinational (Mealy) and equal the capture condition of REQ-009, forced to 0 while rst=1.
REQ-011 On capture:
- shift register <= data
- bit counter <= 0
- state <= SHIFT
REQ-012 In SHIFT without capture and with bit counter < WIDTH-1:
- shift register SHALL shift left by one, zero filled.
- bit counter SHALL increment.
REQ-013 In SHIFT with bit counter = WIDTH-1 and load=0, state SHALL return to IDLE and the shift register SHALL clear to 0.
REQ-014 out SHALL equal shift register bit WIDTH-1 while in SHIFT and 0 in IDLE, so out is registered with no combinational path from inputs.
REQ-015 Latency: data[WIDTH-1] SHALL appear on out in the cycle immediately after the capture edge. data[WIDTH-1-i] SHALL be held for exactly one clock, i clocks later.
REQ-016 Back-to-back words (load held high) SHALL stream with no gap. Bit 0 of word n SHALL be followed directly by the MSB of word n+1.
REQ-017 Changes on data or load between capture edges SHALL NOT affect the word in flight.
REQ-018 load=1 in SHIFT before the last bit SHALL be ignored, with Ren=0.
REQ-019 load=0 in IDLE SHALL keep the block in IDLE with out=0 and Ren=0.
REQ-020 Bit counter SHALL never exceed WIDTH-1; no wrap beyond the word boundary.

Reset
REQ-021 While rst=1, regardless of clk:
- state = IDLE
- shift register = 0
- bit counter = 0
- out = 0
- Ren = 0
REQ-022 After rst deasserts, the first rising edge with load=1 SHALL capture.
REQ-023 rst asserted mid-word SHALL abort the word immediately, with no residual bits emitted after release.
REQ-024 load, data and Ren being X or undriven during reset SHALL NOT propagate to out.

Verification
REQ-025 Reset: rst=1 with load=X and data=X for 2 clocks -> out=0 and Ren=0 throughout.
REQ-026 Single word: release rst, load=1 for one cycle with data=0x65D96B66, then load=0:
- Ren=1 for 1 cycle.
- out over the next 32 cycles = 0,1,1,0,0,1,0,1,1,1,0,1,1,0,0,1,0,1,1,0,1,0,1,1,0,1,1,0,0,1,1,0.
- Then out=0 and IDLE.
REQ-027 Mid-word data change: load held 1 with data=0x65D96B66, data changed to 0x001FFFFC after 20 clocks:
- Remaining bits still follow 0x65D96B66.
- Ren pulses again exactly 32 clocks after the first capture, capturing 0x001FFFFC.
- out then shows 11 zeros, 19 ones, 2 zeros.
REQ-028 Continuous streaming: load=1 for 3 words -> Ren high every 32nd cycle; out has no idle gap between words; total 96 bits match inputs MSB first.
REQ-029 Reset mid-word: assert rst at bit 10 -> out=0 asynchronously; after release with load=0, out stays 0.
REQ-030 Ignored load: load pulses during bits 5 and 20 of a word -> Ren=0 at those cycles and output word is unaltered.
